upsample_sequencer: RTL and testbench

- **Role:** sequences 2x2 nearest-neighbour upsampling of a pixel stream, sitting between the pixel source FIFO and the display-side consumer.
- **Doubling:** pops each source row from the FIFO once and emits every pixel twice, which doubles horizontally. It stores the row in a line buffer and replays it once, which doubles vertically.
- **Framing:** it owns row, column and frame counting and generates the frame and line markers downstream logic needs.
- **Output size:** a SRC_WIDTH x SRC_HEIGHT source frame becomes a 2·SRC_WIDTH x 2·SRC_HEIGHT output frame.

---
 rtl/upsample_sequencer_pkg.sv | 17 +
 rtl/upsample_sequencer_if.sv | 34 +++
 rtl/upsample_sequencer_line_buffer.sv | 36 +++
 rtl/upsample_sequencer.sv | 177 +++++++++++++++++
 tb/tb_upsample_sequencer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/upsample_sequencer_pkg.sv
// Shared definitions for the 2x2 nearest-neighbour upsampling sequencer.
// Holds the default frame geometry and pixel width, plus the FSM state encoding
// used by upsample_sequencer.
package upsample_sequencer_pkg;

  localparam int unsigned DefSrcWidth  = 400;
  localparam int unsigned DefSrcHeight = 300;
  localparam int unsigned DefDataW     = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLive   = 2'd1,
    StPrime  = 2'd2,
    StReplay = 2'd3
  } state_e;

endpackage

// File: rtl/upsample_sequencer_if.sv
// Bundles the source-FIFO side and display-side handshake of the upsampler.
//   fifo_empty/fifo_dout : FWFT source FIFO status and head pixel
//   fifo_read            : pop strobe (combinational)
//   ready                : downstream accepts the current beat
//   dataout/validout     : output pixel beat
//   sof/eol/eof          : frame/line markers, qualified by validout
//   busy                 : sequencer is not idle
// master = the sequencer, slave = the surrounding FIFO/consumer.
interface upsample_sequencer_if
  import upsample_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_read;
  logic              ready;
  logic [DATA_W-1:0] dataout;
  logic              validout;
  logic              sof;
  logic              eol;
  logic              eof;
  logic              busy;

  modport master (
    input  fifo_empty, fifo_dout, ready,
    output fifo_read, dataout, validout, sof, eol, eof, busy
  );

  modport slave (
    output fifo_empty, fifo_dout, ready,
    input  fifo_read, dataout, validout, sof, eol, eof, busy
  );
endinterface

// File: rtl/upsample_sequencer_line_buffer.sv
// Single-port line buffer holding one source row for vertical replay.
// Synchronous write, synchronous read with one cycle of latency; read data is
// held while en_i is low so a prefetched pixel survives output stalls.
//   clk_i   : clock
//   en_i    : port enable
//   we_i    : write when enabled, otherwise read
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data
module upsample_sequencer_line_buffer #(
  parameter int unsigned Depth = 400,
  parameter int unsigned DataW = 8,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [DataW-1:0] wdata_i,
  output logic [DataW-1:0] rdata_o
);
  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/upsample_sequencer.sv
// 2x2 nearest-neighbour upsampling sequencer. Each source row is popped once
// from the FIFO and every pixel is emitted twice (live row); the row is kept in
// a line buffer and replayed once (replay row). Owns column/row/frame counting
// and generates sof/eol/eof markers.
//   clock/reset : system clock, asynchronous active-high reset
//   bus         : FIFO and downstream handshake (master side)
module upsample_sequencer
  import upsample_sequencer_pkg::*;
#(
  parameter int unsigned SRC_WIDTH  = DefSrcWidth,
  parameter int unsigned SRC_HEIGHT = DefSrcHeight,
  parameter int unsigned DATA_W     = DefDataW
) (
  input logic                  clock,
  input logic                  reset,
  upsample_sequencer_if.master bus
);
  localparam int unsigned ColW = $clog2(SRC_WIDTH);
  localparam int unsigned RowW = (SRC_HEIGHT > 1) ? $clog2(SRC_HEIGHT) : 1;

  state_e            state_q, state_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic              phase_q, phase_d;
  logic              copy_q, copy_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              sof_q, sof_d;
  logic              eol_q, eol_d;
  logic              eof_q, eof_d;

  logic              lb_en, lb_we;
  logic [ColW-1:0]   lb_addr;
  logic [DATA_W-1:0] lb_rdata;
  logic              fifo_read;
  logic              load;
  logic              slot_free;
  logic              col_last, row_last;

  assign slot_free = !valid_q || bus.ready;
  assign col_last  = (col_q == ColW'(SRC_WIDTH - 1));
  assign row_last  = (row_q == RowW'(SRC_HEIGHT - 1));

  upsample_sequencer_line_buffer #(
    .Depth (SRC_WIDTH),
    .DataW (DATA_W)
  ) u_line_buffer (
    .clk_i   (clock),
    .en_i    (lb_en),
    .we_i    (lb_we),
    .addr_i  (lb_addr),
    .wdata_i (bus.fifo_dout),
    .rdata_o (lb_rdata)
  );

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    phase_d   = phase_q;
    copy_d    = copy_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    sof_d     = sof_q;
    eol_d     = eol_q;
    eof_d     = eof_q;
    lb_en     = 1'b0;
    lb_we     = 1'b0;
    lb_addr   = col_q;
    fifo_read = 1'b0;
    load      = 1'b0;

    // A free slot with nothing new to present drains the output register.
    if (slot_free) valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!bus.fifo_empty) state_d = StLive;
      end
      StLive: begin
        if (slot_free) begin
          if (!phase_q) begin
            if (!bus.fifo_empty) begin
              load      = 1'b1;
              dout_d    = bus.fifo_dout;
              fifo_read = 1'b1;
              lb_en     = 1'b1;
              lb_we     = 1'b1;
              phase_d   = 1'b1;
            end
          end else begin
            load    = 1'b1;
            phase_d = 1'b0;
            if (col_last) begin
              col_d   = '0;
              copy_d  = 1'b1;
              state_d = StPrime;
            end else begin
              col_d = col_q + ColW'(1);
            end
          end
        end
      end
      StPrime: begin
        // Fetch column 0 so it is waiting in rdata when REPLAY starts.
        lb_en   = 1'b1;
        lb_addr = '0;
        state_d = StReplay;
      end
      StReplay: begin
        if (slot_free) begin
          load = 1'b1;
          if (!phase_q) begin
            dout_d  = lb_rdata;
            phase_d = 1'b1;
            // Prefetch the next column; rdata then holds across any stall.
            if (!col_last) begin
              lb_en   = 1'b1;
              lb_addr = col_q + ColW'(1);
            end
          end else begin
            phase_d = 1'b0;
            if (col_last) begin
              col_d   = '0;
              copy_d  = 1'b0;
              row_d   = row_last ? '0 : row_q + RowW'(1);
              state_d = bus.fifo_empty ? StIdle : StLive;
            end else begin
              col_d = col_q + ColW'(1);
            end
          end
        end
      end
    endcase

    if (load) begin
      valid_d = 1'b1;
      sof_d   = (row_q == '0) && !copy_q && (col_q == '0) && !phase_q;
      eol_d   = col_last && phase_q;
      eof_d   = col_last && phase_q && copy_q && row_last;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      phase_q <= 1'b0;
      copy_q  <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      phase_q <= phase_d;
      copy_q  <= copy_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
    end
  end

  assign bus.fifo_read = fifo_read;
  assign bus.dataout   = dout_q;
  assign bus.validout  = valid_q;
  assign bus.sof       = sof_q;
  assign bus.eol       = eol_q;
  assign bus.eof       = eof_q;
  assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_upsample_sequencer.sv
// Directed bench for upsample_sequencer on a 4x2 source frame: reset values,
// streaming, backpressure, FIFO underrun, reset mid-replay and back-to-back
// frames. Inputs change on the falling edge; outputs are sampled there too.
module tb_upsample_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  upsample_sequencer_if #(.DATA_W(8)) bus ();

  upsample_sequencer #(
    .SRC_WIDTH  (4),
    .SRC_HEIGHT (2),
    .DATA_W     (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Hand-computed pixel offsets of the 32 output beats of one 4x2 frame.
  int exp_pix [32] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2, 2, 3, 3,
                       4, 4, 5, 5, 6, 6, 7, 7, 4, 4, 5, 5, 6, 6, 7, 7};

  logic [7:0]  fifo_q [$];
  logic [10:0] beat_q [$];   // {data, sof, eol, eof}
  int          beat_cyc [$];
  int          cyc = 0;
  int          pops = 0;
  int          hold_err = 0;
  int          rd_bad = 0;
  bit          rd_seen = 1'b0;
  bit          toggle = 1'b0;
  bit          hold_pend = 1'b0;
  logic [10:0] hold_val;

  always @(posedge clock) begin
    rd_seen <= bus.fifo_read;
    if (bus.fifo_read && bus.fifo_empty) rd_bad <= rd_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clock);
    cyc++;
    if (hold_pend) begin
      if (!bus.validout || {bus.dataout, bus.sof, bus.eol, bus.eof} !== hold_val) hold_err++;
      hold_pend = 1'b0;
    end
    if (rd_seen) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pops++;
    end
    bus.ready      = toggle ? ~bus.ready : 1'b1;
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    if (bus.validout && bus.ready) begin
      beat_q.push_back({bus.dataout, bus.sof, bus.eol, bus.eof});
      beat_cyc.push_back(cyc);
    end
    if (bus.validout && !bus.ready) begin
      hold_pend = 1'b1;
      hold_val  = {bus.dataout, bus.sof, bus.eol, bus.eof};
    end
  endtask

  task automatic push_frame(input int base);
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'(base + i));
  endtask

  task automatic clear_beats();
    beat_q.delete();
    beat_cyc.delete();
  endtask

  task automatic run_beats(input string tag, input int n, input int budget);
    int k = 0;
    while (beat_q.size() < n && k < budget) begin
      cycle();
      k++;
    end
    check(tag, beat_q.size(), n);
  endtask

  task automatic check_frame(input string tag, input int base, input int first);
    logic [10:0] e;
    for (int i = 0; i < 32; i++) begin
      e = {8'(base + exp_pix[i]), 1'(i == 0), 1'(i % 8 == 7), 1'(i == 31)};
      if (beat_q.size() > first + i) check(tag, beat_q[first + i], e);
    end
  endtask

  initial begin
    int start;
    int low_cnt;
    int busy_low;
    int sof_cnt;
    int eof_cnt;

    bus.ready      = 1'b1;
    bus.fifo_empty = 1'b1;
    bus.fifo_dout  = 8'h00;
    #1 reset = 1'b1;
    repeat (3) cycle();

    check("rst_validout", bus.validout, 0);
    check("rst_dataout", bus.dataout, 0);
    check("rst_sof", bus.sof, 0);
    check("rst_eol", bus.eol, 0);
    check("rst_eof", bus.eof, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_fifo_read", bus.fifo_read, 0);

    // Streaming with ready held high.
    reset = 1'b0;
    cycle();
    push_frame(0);
    pops = 0;
    start = cyc + 1;
    run_beats("stream_beats", 32, 200);
    check_frame("stream_beat", 0, 0);
    if (beat_cyc.size() > 0) check("stream_latency", beat_cyc[0] - start, 2);
    for (int i = 1; i < 32; i++) begin
      if (beat_cyc.size() > i)
        check("stream_gap", beat_cyc[i] - beat_cyc[i-1], (i == 8 || i == 24) ? 2 : 1);
    end
    repeat (4) cycle();
    check("stream_pops", pops, 8);
    check("stream_idle_busy", bus.busy, 0);
    check("stream_idle_valid", bus.validout, 0);

    // Backpressure: ready toggles every cycle.
    clear_beats();
    pops = 0;
    hold_err = 0;
    toggle = 1'b1;
    push_frame(0);
    run_beats("bp_beats", 32, 400);
    check_frame("bp_beat", 0, 0);
    toggle = 1'b0;
    repeat (4) cycle();
    check("bp_hold", hold_err, 0);
    check("bp_pops", pops, 8);

    // Underrun: only pixels 0,1 available, five empty cycles, then the rest.
    clear_beats();
    fifo_q.push_back(8'd0);
    fifo_q.push_back(8'd1);
    for (int k = 0; k < 50 && fifo_q.size() != 0; k++) cycle();
    low_cnt = bus.validout ? 0 : 1;
    repeat (4) begin
      cycle();
      if (!bus.validout) low_cnt++;
    end
    for (int i = 2; i < 8; i++) fifo_q.push_back(8'(i));
    check("underrun_gap_low", low_cnt, 3);
    run_beats("underrun_beats", 32, 300);
    check_frame("underrun_beat", 0, 0);
    repeat (4) cycle();

    // Reset during the row-0 replay, then a fresh frame 10..17.
    clear_beats();
    push_frame(0);
    run_beats("pre_reset_beats", 10, 100);
    #2 reset = 1'b1;
    #1;
    check("midrst_validout", bus.validout, 0);
    check("midrst_dataout", bus.dataout, 0);
    check("midrst_sof", bus.sof, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_fifo_read", bus.fifo_read, 0);
    fifo_q.delete();
    push_frame(10);
    clear_beats();
    repeat (2) cycle();
    reset = 1'b0;
    run_beats("post_reset_beats", 32, 200);
    check_frame("post_reset_beat", 10, 0);
    repeat (4) cycle();

    // Two frames back to back with the FIFO kept non-empty.
    clear_beats();
    push_frame(20);
    push_frame(28);
    busy_low = 0;
    for (int k = 0; k < 400 && beat_q.size() < 64; k++) begin
      cycle();
      if (beat_q.size() > 0 && beat_q.size() < 64 && !bus.busy) busy_low++;
    end
    check("b2b_beats", beat_q.size(), 64);
    check_frame("b2b_frame0", 20, 0);
    check_frame("b2b_frame1", 28, 32);
    sof_cnt = 0;
    eof_cnt = 0;
    foreach (beat_q[i]) begin
      if (beat_q[i][2]) sof_cnt++;
      if (beat_q[i][0]) eof_cnt++;
    end
    check("b2b_sof_count", sof_cnt, 2);
    check("b2b_eof_count", eof_cnt, 2);
    check("b2b_busy_low", busy_low, 0);
    if (beat_cyc.size() > 32) check("b2b_frame_gap", beat_cyc[32] - beat_cyc[31], 1);
    repeat (4) cycle();

    check("read_while_empty", rd_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
